// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the data port and the shared
// memory port of mem_port_arbiter.
// The slave modport is the arbiter's view.
// The master modport is the view of the requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  // data-memory requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [1:0]        d_size;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // single-port memory
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [1:0]        m_size;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_size,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata, m_size,
    input  m_rdata
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output d_req, d_we, d_addr, d_wdata, d_size,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_size,
    output m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access.
// It runs one transaction at a time with a fixed memory latency.
// Data accesses have priority over fetch.
// Optional feature macro: ARB_STARVE_GUARD_EN. When it is defined, a fetch is
// forced through after STARVE_MAX consecutive data grants issued while the
// fetch was pending.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must lie in 1..15");
  end

  state_t            state, state_n;
  logic [3:0]        lat_cnt, lat_cnt_n;
  logic              win_data, win_data_n;
  logic              win_we, win_we_n;

  logic              m_en_q, m_en_n;
  logic              m_we_q, m_we_n;
  logic [ADDR_W-1:0] m_addr_q, m_addr_n;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_n;
  logic [1:0]        m_size_q, m_size_n;
  logic              f_gnt_q, f_gnt_n;
  logic              d_gnt_q, d_gnt_n;
  logic              f_rvalid_q, f_rvalid_n;
  logic              d_rvalid_q, d_rvalid_n;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_n;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_n;

  logic              arb_any;
  logic              arb_data;
  logic              arb_fire;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0]        starve_cnt;

  // Pick the winner; a fetch that has waited STARVE_MAX data grants overrides data priority.
  always_comb begin
    arb_any  = bus.d_req || bus.f_req;
    arb_data = bus.d_req;
    if (bus.f_req && (starve_cnt == 4'(STARVE_MAX))) begin
      arb_data = 1'b0;
    end
    arb_fire = ((state == IDLE) || (state == RESP)) && arb_any;
  end

  // Count data grants issued while fetch is pending; any fetch grant or idle fetch clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!bus.f_req) begin
      starve_cnt <= 4'd0;
    end else if (arb_fire && !arb_data) begin
      starve_cnt <= 4'd0;
    end else if (arb_fire && arb_data && (starve_cnt != 4'hF)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  // Pick the winner with strict data priority.
  always_comb begin
    arb_any  = bus.d_req || bus.f_req;
    arb_data = bus.d_req;
    arb_fire = ((state == IDLE) || (state == RESP)) && arb_any;
  end
`endif

  // Next state and next registered outputs.
  // The m_* registers double as the transaction latches and are set at the arbitration edge.
  always_comb begin
    state_n    = state;
    lat_cnt_n  = lat_cnt;
    win_data_n = win_data;
    win_we_n   = win_we;
    m_en_n     = 1'b0;
    m_we_n     = 1'b0;
    m_addr_n   = m_addr_q;
    m_wdata_n  = m_wdata_q;
    m_size_n   = m_size_q;
    f_gnt_n    = 1'b0;
    d_gnt_n    = 1'b0;
    f_rvalid_n = 1'b0;
    d_rvalid_n = 1'b0;
    f_rdata_n  = f_rdata_q;
    d_rdata_n  = d_rdata_q;

    case (state)
      IDLE, RESP: begin
        if (arb_fire) begin
          state_n    = ISSUE;
          win_data_n = arb_data;
          m_en_n     = 1'b1;
          if (arb_data) begin
            win_we_n  = bus.d_we;
            m_we_n    = bus.d_we;
            m_addr_n  = bus.d_addr;
            m_wdata_n = bus.d_wdata;
            m_size_n  = bus.d_size;
            d_gnt_n   = 1'b1;
          end else begin
            win_we_n  = 1'b0;
            m_we_n    = 1'b0;
            m_addr_n  = bus.f_addr;
            m_wdata_n = '0;
            m_size_n  = 2'd2;
            f_gnt_n   = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end

      ISSUE: begin
        state_n   = WAIT;
        lat_cnt_n = LAT_LOAD;
      end

      WAIT: begin
        if (lat_cnt == 4'd0) begin
          state_n = RESP;
          if (win_data) begin
            d_rdata_n  = win_we ? '0 : bus.m_rdata;
            d_rvalid_n = 1'b1;
          end else begin
            f_rdata_n  = bus.m_rdata;
            f_rvalid_n = 1'b1;
          end
        end else begin
          lat_cnt_n = lat_cnt - 4'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State, latches and every output register; reset discards any in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= 4'd0;
      win_data   <= 1'b0;
      win_we     <= 1'b0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_size_q   <= 2'd0;
      f_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state      <= state_n;
      lat_cnt    <= lat_cnt_n;
      win_data   <= win_data_n;
      win_we     <= win_we_n;
      m_en_q     <= m_en_n;
      m_we_q     <= m_we_n;
      m_addr_q   <= m_addr_n;
      m_wdata_q  <= m_wdata_n;
      m_size_q   <= m_size_n;
      f_gnt_q    <= f_gnt_n;
      d_gnt_q    <= d_gnt_n;
      f_rvalid_q <= f_rvalid_n;
      d_rvalid_q <= d_rvalid_n;
      f_rdata_q  <= f_rdata_n;
      d_rdata_q  <= d_rdata_n;
    end
  end

  assign bus.m_en     = m_en_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_size   = m_size_q;
  assign bus.f_gnt    = f_gnt_q;
  assign bus.d_gnt    = d_gnt_q;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// It uses three instances, one each with MEM_LAT = 1, 3 and 2.
// Each instance has a memory model that drives a valid word only in the
// exact cycle MEM_LAT after m_en. In every other cycle the model drives a
// poison value.
// Build with ARB_STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   f_count;
  int   k;
  logic is_gnt, exp_d, exp_f, exp_en, exp_rv;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_c ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clock(clock), .reset(reset), .bus(bus_b));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_c (
    .clock(clock), .reset(reset), .bus(bus_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory models: remember the address at m_en and count the cycles since then.
  int          age_a, age_b, age_c;
  logic [31:0] addr_a, addr_b, addr_c;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      age_a <= 100; addr_a <= '0;
    end else if (bus_a.m_en) begin
      age_a <= 1; addr_a <= bus_a.m_addr;
    end else if (age_a < 100) begin
      age_a <= age_a + 1;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      age_b <= 100; addr_b <= '0;
    end else if (bus_b.m_en) begin
      age_b <= 1; addr_b <= bus_b.m_addr;
    end else if (age_b < 100) begin
      age_b <= age_b + 1;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      age_c <= 100; addr_c <= '0;
    end else if (bus_c.m_en) begin
      age_c <= 1; addr_c <= bus_c.m_addr;
    end else if (age_c < 100) begin
      age_c <= age_c + 1;
    end
  end

  assign bus_a.m_rdata = (age_a == 1) ? (addr_a ^ 32'h01500093) : 32'hBADBAD00;
  assign bus_b.m_rdata = (age_b == 3) ? (addr_b ^ 32'h01500093) : 32'hBADBAD00;
  assign bus_c.m_rdata = (age_c == 2) ? (addr_c ^ 32'h01500093) : 32'hBADBAD00;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    f_count = 0;
    reset = 1'b1;
    bus_a.f_req = 0; bus_a.f_addr = '0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = '0; bus_a.d_wdata = '0; bus_a.d_size = 2'd0;
    bus_b.f_req = 0; bus_b.f_addr = '0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = '0; bus_b.d_wdata = '0; bus_b.d_size = 2'd0;
    bus_c.f_req = 0; bus_c.f_addr = '0; bus_c.d_req = 0; bus_c.d_we = 0;
    bus_c.d_addr = '0; bus_c.d_wdata = '0; bus_c.d_size = 2'd0;

    // reset values
    tick(); tick();
    check_output("rst_m_en", bus_a.m_en, 0);
    check_output("rst_f_gnt", bus_a.f_gnt, 0);
    check_output("rst_d_gnt", bus_a.d_gnt, 0);
    check_output("rst_f_rvalid", bus_a.f_rvalid, 0);
    check_output("rst_d_rvalid", bus_a.d_rvalid, 0);
    check_output("rst_m_addr", bus_a.m_addr, 0);
    check_output("rst_f_rdata", bus_a.f_rdata, 0);
    check_output("rst_d_rdata", bus_a.d_rdata, 0);
    reset = 1'b0;
    tick();

    // single fetch, MEM_LAT=1 (cycle 0 -> gnt cycle 1 -> rvalid cycle 3)
    bus_a.f_req = 1; bus_a.f_addr = 32'h01000000;
    tick();
    check_output("fetch_f_gnt", bus_a.f_gnt, 1);
    check_output("fetch_d_gnt", bus_a.d_gnt, 0);
    check_output("fetch_m_en", bus_a.m_en, 1);
    check_output("fetch_m_addr", bus_a.m_addr, 32'h01000000);
    check_output("fetch_m_we", bus_a.m_we, 0);
    check_output("fetch_m_size", bus_a.m_size, 2);
    bus_a.f_req = 0;
    tick();
    check_output("fetch_c2_m_en", bus_a.m_en, 0);
    check_output("fetch_c2_f_gnt", bus_a.f_gnt, 0);
    check_output("fetch_c2_f_rvalid", bus_a.f_rvalid, 0);
    tick();
    check_output("fetch_f_rvalid", bus_a.f_rvalid, 1);
    check_output("fetch_f_rdata", bus_a.f_rdata, 32'h00500093);
    tick();
    check_output("fetch_c4_f_rvalid", bus_a.f_rvalid, 0);
    check_output("fetch_hold_f_rdata", bus_a.f_rdata, 32'h00500093);

    // data write of a byte
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 32'h01000100;
    bus_a.d_wdata = 32'hDEADBEEF; bus_a.d_size = 2'd0;
    tick();
    check_output("wr_d_gnt", bus_a.d_gnt, 1);
    check_output("wr_f_gnt", bus_a.f_gnt, 0);
    check_output("wr_m_en", bus_a.m_en, 1);
    check_output("wr_m_we", bus_a.m_we, 1);
    check_output("wr_m_size", bus_a.m_size, 0);
    check_output("wr_m_wdata", bus_a.m_wdata, 32'hDEADBEEF);
    check_output("wr_m_addr", bus_a.m_addr, 32'h01000100);
    bus_a.d_req = 0; bus_a.d_we = 0;
    tick();
    check_output("wr_c2_m_we", bus_a.m_we, 0);
    check_output("wr_c2_d_rvalid", bus_a.d_rvalid, 0);
    tick();
    check_output("wr_d_rvalid", bus_a.d_rvalid, 1);
    check_output("wr_d_rdata", bus_a.d_rdata, 0);
    check_output("wr_f_rvalid", bus_a.f_rvalid, 0);
    check_output("wr_f_rdata_kept", bus_a.f_rdata, 32'h00500093);
    tick();

    // fetch and data read raised together: data first, fetch issues right after RESP
    bus_a.f_req = 1; bus_a.f_addr = 32'h01000010;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h01000200; bus_a.d_size = 2'd2;
    tick();
    check_output("both_d_gnt", bus_a.d_gnt, 1);
    check_output("both_f_gnt_c1", bus_a.f_gnt, 0);
    check_output("both_m_addr_d", bus_a.m_addr, 32'h01000200);
    bus_a.d_req = 0;
    tick();
    check_output("both_f_gnt_c2", bus_a.f_gnt, 0);
    tick();
    check_output("both_d_rvalid", bus_a.d_rvalid, 1);
    check_output("both_d_rdata", bus_a.d_rdata, 32'h00500293);
    check_output("both_f_gnt_c3", bus_a.f_gnt, 0);
    tick();
    check_output("both_f_gnt", bus_a.f_gnt, 1);
    check_output("both_m_en_f", bus_a.m_en, 1);
    check_output("both_m_addr_f", bus_a.m_addr, 32'h01000010);
    check_output("both_d_rvalid_off", bus_a.d_rvalid, 0);
    bus_a.f_req = 0;
    tick(); tick();
    check_output("both_f_rvalid", bus_a.f_rvalid, 1);
    check_output("both_f_rdata", bus_a.f_rdata, 32'h00500083);
    tick();

    // MEM_LAT=3, continuous data reads: m_en every 5 cycles, rvalid 5 cycles after request
    bus_b.d_req = 1; bus_b.d_we = 0; bus_b.d_addr = 32'h00000040; bus_b.d_size = 2'd2;
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp_en = ((c % 5) == 1);
      exp_rv = ((c % 5) == 0);
      check_output($sformatf("lat3_m_en_c%0d", c), bus_b.m_en, exp_en);
      check_output($sformatf("lat3_d_rvalid_c%0d", c), bus_b.d_rvalid, exp_rv);
      if (exp_rv) check_output($sformatf("lat3_d_rdata_c%0d", c), bus_b.d_rdata, 32'h015000D3);
      if (c == 15) bus_b.d_req = 0;
    end
    tick();
    check_output("lat3_m_en_after", bus_b.m_en, 0);

    // both requests held continuously: strict priority, or 4 data then 1 fetch with the guard
    bus_a.f_req = 1; bus_a.f_addr = 32'h01000020;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h01000300; bus_a.d_size = 2'd2;
    for (int c = 1; c <= 99; c++) begin
      tick();
      k = (c - 1) / 3;
      is_gnt = ((c % 3) == 1);
`ifdef ARB_STARVE_GUARD_EN
      exp_d = is_gnt && ((k % 5) != 4);
      exp_f = is_gnt && ((k % 5) == 4);
`else
      exp_d = is_gnt;
      exp_f = 1'b0;
`endif
      check_output($sformatf("starve_d_gnt_c%0d", c), bus_a.d_gnt, exp_d);
      check_output($sformatf("starve_f_gnt_c%0d", c), bus_a.f_gnt, exp_f);
      if (bus_a.f_gnt) f_count++;
    end
`ifdef ARB_STARVE_GUARD_EN
    check_output("starve_f_total", f_count, 6);
`else
    check_output("starve_f_total", f_count, 0);
`endif
    bus_a.f_req = 0; bus_a.d_req = 0;
    tick();
    check_output("starve_m_en_after", bus_a.m_en, 0);
    tick();

    // MEM_LAT=2, reset asserted during WAIT
    bus_c.d_req = 1; bus_c.d_we = 0; bus_c.d_addr = 32'h00000080; bus_c.d_size = 2'd2;
    tick();
    check_output("rstw_d_gnt", bus_c.d_gnt, 1);
    check_output("rstw_m_addr", bus_c.m_addr, 32'h00000080);
    bus_c.d_req = 0;
    tick();
    reset = 1'b1;
    #1;
    check_output("rstw_async_m_addr", bus_c.m_addr, 0);
    check_output("rstw_async_m_en", bus_c.m_en, 0);
    check_output("rstw_async_d_gnt", bus_c.d_gnt, 0);
    check_output("rstw_async_d_rvalid", bus_c.d_rvalid, 0);
    check_output("rstw_async_a_m_addr", bus_a.m_addr, 0);
    check_output("rstw_async_a_f_rdata", bus_a.f_rdata, 0);
    tick(); tick();
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_output($sformatf("rstw_no_rvalid_c%0d", c), bus_c.d_rvalid, 0);
      check_output($sformatf("rstw_no_m_en_c%0d", c), bus_c.m_en, 0);
    end

    // served normally after reset: gnt in cycle 1, rvalid in cycle 4
    bus_c.d_req = 1; bus_c.d_addr = 32'h000000C0;
    tick();
    check_output("post_d_gnt", bus_c.d_gnt, 1);
    check_output("post_m_en", bus_c.m_en, 1);
    bus_c.d_req = 0;
    tick();
    check_output("post_c2_d_rvalid", bus_c.d_rvalid, 0);
    tick();
    check_output("post_c3_d_rvalid", bus_c.d_rvalid, 0);
    tick();
    check_output("post_d_rvalid", bus_c.d_rvalid, 1);
    check_output("post_d_rdata", bus_c.d_rdata, 32'h01500053);
    tick();
    check_output("post_c5_d_rvalid", bus_c.d_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares one single-port memory between the instruction-fetch requester and the data-memory requester of the five-stage pipeline. It issues at most one transaction at a time. For each transaction it counts a fixed memory latency and returns read data or a write acknowledgement to the winning requester. Data accesses have priority over fetch. An optional anti-starvation guard bounds how long fetch can be locked out.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 1: cycles from `m_en` to valid `m_rdata`. Legal range is 1 to 15.
- `STARVE_MAX`, default 4: number of consecutive data grants allowed while fetch is pending. Legal range is 1 to 15. Used only when `ARB_STARVE_GUARD_EN` is defined.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `f_req` in 1: fetch request; held high until `f_gnt`.
- `f_addr` in ADDR_W: fetch address; stable while `f_req` is high.
- `f_gnt` out 1: one-cycle pulse when the fetch transaction is issued.
- `f_rvalid` out 1: one-cycle pulse when `f_rdata` is valid.
- `f_rdata` out DATA_W: fetched word.
- `d_req` in 1: data request; held high until `d_gnt`.
- `d_we` in 1: 1 selects write, 0 selects read.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: write data.
- `d_size` in 2: access size; 0 = byte, 1 = half, 2 = word.
- `d_gnt` out 1: one-cycle issue pulse.
- `d_rvalid` out 1: one-cycle pulse; carries read data, or acknowledges a write.
- `d_rdata` out DATA_W: read data; 0 for writes.
- `m_en` out 1: memory strobe, one cycle per transaction.
- `m_we` out 1: memory write enable.
- `m_addr` out ADDR_W: memory address.
- `m_wdata` out DATA_W: memory write data.
- `m_size` out 2: memory access size.
- `m_rdata` in DATA_W: memory read data, valid exactly `MEM_LAT` cycles after the `m_en` cycle.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP. Reset state is IDLE.
- Arbitration is evaluated in IDLE and in RESP.
  - `d_req` high: data wins.
  - Otherwise, `f_req` high: fetch wins.
  - Otherwise, the next state is IDLE.
- At the arbitration edge:
  - Latch the winner ID, address, we, wdata and size.
  - A fetch is forced to we=0 and size=2.
  - Go to ISSUE.
- ISSUE lasts one cycle.
  - `m_en`=1; `m_we`, `m_addr`, `m_wdata` and `m_size` are driven from the latches.
  - The winner's gnt is 1.
  - Next state is WAIT with the latency counter loaded with `MEM_LAT`-1.
- WAIT decrements the counter each cycle.
  - When the counter is 0, capture `m_rdata` (or 0 for a write) into the winner's rdata register and go to RESP.
- RESP lasts one cycle.
  - The winner's rvalid is 1.
  - Arbitration runs as in IDLE.
- A requester may raise req again in the same cycle as its gnt. That req is treated as a new transaction.
- When both requests are high in the same cycle, data wins unless the starvation guard forces fetch.
- The loser's req stays pending. It has no timeout.
- A req dropped before gnt is simply not served. Requesters must not do this, and the arbiter does not check for it.
- `f_rdata` and `d_rdata` hold their last value until the next capture for the same requester.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - `m_en`, `m_we`, `f_gnt`, `d_gnt`, `f_rvalid` and `d_rvalid` = 0.
  - `m_addr`, `m_wdata`, `m_size`, `f_rdata` and `d_rdata` = 0.
  - starvation counter = 0.
- For a request sampled at the end of cycle 0:
  - gnt and `m_en` in cycle 1.
  - `m_rdata` valid in cycle 1+`MEM_LAT`.
  - rvalid in cycle 2+`MEM_LAT`.
- Request-to-rvalid latency is `MEM_LAT`+2 cycles.
- With back-to-back requests, a new ISSUE immediately follows RESP. Period is `MEM_LAT`+2 cycles.
- `m_en` is high for exactly 1 cycle per transaction. gnt and rvalid are never high together for the same requester.
- Reset asserted mid-transaction:
  - All outputs go to reset values asynchronously.
  - The in-flight transaction is discarded; no rvalid is produced.
  - After reset deasserts, arbitration restarts from IDLE.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each data grant issued while `f_req` is high.
  - When the counter equals `STARVE_MAX` and `f_req` is high, the next arbitration grants fetch even if `d_req` is high.
  - The counter clears on any fetch grant or any cycle with `f_req` low.
- `ARB_STARVE_GUARD_EN` not defined:
  - Strict data priority. The counter is absent.
  - Fetch can starve indefinitely.

## Test plan
- Reset, then a single fetch: `f_addr`=0x01000000 with `MEM_LAT`=1 and memory returning 0x00500093.
  - Expect `f_gnt` in cycle 1, `m_en` in cycle 1 with `m_addr`=0x01000000, `m_we`=0 and `m_size`=2.
  - Expect `f_rvalid` in cycle 3 with `f_rdata`=0x00500093.
- Data write: `d_we`=1, `d_addr`=0x01000100, `d_wdata`=0xDEADBEEF, `d_size`=0.
  - Expect `m_we`=1, `m_size`=0 and `m_wdata`=0xDEADBEEF in the ISSUE cycle.
  - Expect `d_rvalid` pulse with `d_rdata`=0.
- `f_req` and `d_req` both raised in the same cycle.
  - Expect `d_gnt` first.
  - Expect `f_gnt` in the cycle immediately after `d_rvalid`, i.e. the RESP-to-ISSUE back-to-back case.
- `MEM_LAT`=3 with continuous `d_req` reads.
  - Expect `m_en` once every 5 cycles and rvalid exactly 5 cycles after each request.
- Guard enabled, `STARVE_MAX`=4, `d_req` and `f_req` held high continuously.
  - Expect exactly 4 data grants, then 1 fetch grant, repeating.
  - Guard disabled: expect zero fetch grants over 100 cycles.
- Reset asserted in the WAIT cycle with `MEM_LAT`=2.
  - Expect all outputs 0 immediately and no rvalid afterward.
  - Expect a new request after reset to be served normally with latency `MEM_LAT`+2.
